// File: rtl/mito_pkg.sv
// Shared constants and elaboration-time helpers for the adder-tree accumulator.
package mito_pkg;

  localparam int unsigned DefNIn   = 9;
  localparam int unsigned DefInW   = 16;
  localparam int unsigned DefMaxCh = 64;
  // Headroom of the saturated output over a single product.
  localparam int unsigned OutGuardW = 4;
  // Side-band flags carried ahead of the bias: last, first, relu.
  localparam int unsigned SideFlagW = 3;

  typedef enum logic {
    StFirst,
    StAccum
  } grp_state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  // Operand count entering reduction level lvl of an n-input tree.
  function automatic int unsigned level_cnt(input int unsigned n, input int unsigned lvl);
    int unsigned c;
    c = n;
    for (int unsigned i = 0; i < lvl; i++) begin
      c = (c + 1) / 2;
    end
    return c;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered pairwise reduction level; odd operand passes through sign-extended.
module adder_tree_level #(
  parameter int unsigned N_OPS  = 2,
  parameter int unsigned OP_W   = 16,
  parameter int unsigned SIDE_W = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  input  logic [N_OPS*OP_W-1:0]                  in_data,
  input  logic [SIDE_W-1:0]                      in_side,
  output logic                                   out_valid,
  output logic [((N_OPS+1)/2)*(OP_W+1)-1:0]      out_data,
  output logic [SIDE_W-1:0]                      out_side
);

  localparam int unsigned NOut = (N_OPS + 1) / 2;

  logic [NOut*(OP_W+1)-1:0] sum_d;

  for (genvar k = 0; k < NOut; k++) begin : g_op
    logic [OP_W-1:0] a;
    assign a = in_data[2*k*OP_W +: OP_W];
    if (2 * k + 1 < N_OPS) begin : g_pair
      logic [OP_W-1:0] b;
      assign b = in_data[(2*k+1)*OP_W +: OP_W];
      assign sum_d[k*(OP_W+1) +: OP_W+1] = {a[OP_W-1], a} + {b[OP_W-1], b};
    end else begin : g_pass
      assign sum_d[k*(OP_W+1) +: OP_W+1] = {a[OP_W-1], a};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
    end
  end

  // Data and side-band only move with a valid beat; no reset needed.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      out_data <= sum_d;
      out_side <= in_side;
    end
  end

endmodule

// File: rtl/adder_tree_acc.sv
// Pipelined adder tree over N_IN products with per-group accumulation, bias, ReLU and
// saturation.
module adder_tree_acc
  import mito_pkg::*;
#(
  parameter int unsigned N_IN   = DefNIn,
  parameter int unsigned IN_W   = DefInW,
  parameter int unsigned OUT_W  = IN_W + OutGuardW,
  parameter int unsigned MAX_CH = DefMaxCh
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic [N_IN*IN_W-1:0]     products,
  input  logic signed [OUT_W-1:0]  bias,
  input  logic                     relu_en,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_sum,
  output logic                     err_ovf
);

  localparam int unsigned D     = clog2(N_IN);
  localparam int unsigned TreeW = IN_W + D;
  localparam int unsigned CntW  = clog2(MAX_CH) + 1;
  localparam int unsigned AccW  = IN_W + D + clog2(MAX_CH) + 1;
  localparam int unsigned SideW = SideFlagW + OUT_W;

  grp_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            forced_last;
  logic            beat_last;
  logic [SideW-1:0] side_in;

  // The MAX_CH-th beat of an unterminated group closes it.
  assign forced_last = (cnt_q == CntW'(MAX_CH - 1));
  assign beat_last   = in_last | forced_last;
  assign side_in     = {beat_last, (state_q == StFirst), relu_en, bias};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (in_valid) begin
      if (beat_last) begin
        state_d = StFirst;
        cnt_d   = '0;
        err_d   = err_q | (forced_last & ~in_last);
      end else begin
        state_d = StAccum;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  for (genvar l = 0; l < D; l++) begin : g_lvl
    localparam int unsigned NI = level_cnt(N_IN, l);
    localparam int unsigned NO = level_cnt(N_IN, l + 1);
    localparam int unsigned WI = IN_W + l;

    logic [NI*WI-1:0]     d_in;
    logic                 v_in;
    logic [SideW-1:0]     s_in;
    logic [NO*(WI+1)-1:0] d_out;
    logic                 v_out;
    logic [SideW-1:0]     s_out;

    if (l == 0) begin : g_src
      assign d_in = products;
      assign v_in = in_valid;
      assign s_in = side_in;
    end else begin : g_src
      assign d_in = g_lvl[l-1].d_out;
      assign v_in = g_lvl[l-1].v_out;
      assign s_in = g_lvl[l-1].s_out;
    end

    adder_tree_level #(
      .N_OPS  (NI),
      .OP_W   (WI),
      .SIDE_W (SideW)
    ) u_level (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v_in),
      .in_data   (d_in),
      .in_side   (s_in),
      .out_valid (v_out),
      .out_data  (d_out),
      .out_side  (s_out)
    );
  end

  logic signed [TreeW-1:0] tree_sum;
  logic                    tree_valid;
  logic                    t_last, t_first, t_relu;
  logic signed [OUT_W-1:0] t_bias;

  assign tree_sum   = g_lvl[D-1].d_out;
  assign tree_valid = g_lvl[D-1].v_out;
  assign {t_last, t_first, t_relu, t_bias} = g_lvl[D-1].s_out;

  logic signed [AccW-1:0]  acc_q, acc_d, relu_val;
  logic [AccW-OUT_W:0]     hi_bits;
  logic signed [OUT_W-1:0] sat_val;

  always_comb begin
    acc_d = acc_q;
    if (tree_valid) begin
      acc_d = (t_first ? AccW'(t_bias) : acc_q) + AccW'(tree_sum);
    end
    relu_val = (t_relu && acc_d[AccW-1]) ? '0 : acc_d;
    // Fits in OUT_W when every bit above the output sign bit matches it.
    hi_bits = relu_val[AccW-1:OUT_W-1];
    if ((hi_bits == '0) || (hi_bits == '1)) begin
      sat_val = relu_val[OUT_W-1:0];
    end else if (relu_val[AccW-1]) begin
      sat_val = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      sat_val = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFirst;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      acc_q     <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      acc_q     <= acc_d;
      out_valid <= tree_valid & t_last;
      if (tree_valid && t_last) begin
        out_sum <= sat_val;
      end
    end
  end

  assign err_ovf = err_q;

endmodule

// File: tb/tb_adder_tree_acc.sv
// Directed self-checking bench for adder_tree_acc with the default 9-tap configuration.
module tb_adder_tree_acc;

  localparam int unsigned N_IN   = 9;
  localparam int unsigned IN_W   = 16;
  localparam int unsigned OUT_W  = 20;
  localparam int unsigned MAX_CH = 64;
  localparam int          LAT    = 5;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_last;
  logic [N_IN*IN_W-1:0]    products;
  logic signed [OUT_W-1:0] bias;
  logic                    relu_en;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out_sum;
  logic                    err_ovf;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int beat_cyc;
  int c64;
  int res_q[$];
  int res_cyc_q[$];

  adder_tree_acc #(
    .N_IN   (N_IN),
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .MAX_CH (MAX_CH)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .products  (products),
    .bias      (bias),
    .relu_en   (relu_en),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .err_ovf   (err_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      res_q.push_back(int'(out_sum));
      res_cyc_q.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [N_IN*IN_W-1:0] ramp();
    logic [N_IN*IN_W-1:0] p;
    for (int k = 0; k < N_IN; k++) p[k*IN_W +: IN_W] = IN_W'(k + 1);
    return p;
  endfunction

  function automatic logic [N_IN*IN_W-1:0] fill(input int v);
    logic [N_IN*IN_W-1:0] p;
    for (int k = 0; k < N_IN; k++) p[k*IN_W +: IN_W] = IN_W'(v);
    return p;
  endfunction

  task automatic scramble();
    for (int k = 0; k < N_IN; k++) products[k*IN_W +: IN_W] = IN_W'($urandom);
    bias    = OUT_W'($urandom);
    in_last = 1'b1;
    relu_en = 1'b1;
  endtask

  task automatic beat(input logic [N_IN*IN_W-1:0] p, input int b, input logic last,
                      input logic relu);
    in_valid = 1'b1;
    products = p;
    bias     = OUT_W'(b);
    in_last  = last;
    relu_en  = relu;
    @(posedge clk);
    #1;
    beat_cyc = cyc;
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_test();
    res_q.delete();
    res_cyc_q.delete();
  endtask

  task automatic expect_result(input string tag, input int exp);
    if (res_q.size() != 0) check_eq(tag, res_q.pop_front(), exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    scramble();
    idle(3);
    check_eq("reset out_valid", out_valid, 0);
    check_eq("reset out_sum", out_sum, 0);
    check_eq("reset err_ovf", err_ovf, 0);
    rst = 1'b0;
    idle(2);

    // Single-beat group, latency and bias.
    start_test();
    beat(ramp(), 1, 1'b1, 1'b0);
    idle(LAT + 3);
    check_eq("single count", res_q.size(), 1);
    if (res_cyc_q.size() != 0) check_eq("single latency", res_cyc_q[0] - beat_cyc + 1, LAT);
    expect_result("single sum", 46);

    // Two beats; bias on the second beat must be ignored.
    start_test();
    beat(ramp(), 1, 1'b0, 1'b0);
    beat(fill(2), 100, 1'b1, 1'b0);
    idle(LAT + 3);
    check_eq("two-beat count", res_q.size(), 1);
    expect_result("two-beat sum", 64);

    // ReLU on and off, back-to-back single-beat groups.
    start_test();
    beat(fill(-10), 0, 1'b1, 1'b1);
    beat(fill(-10), 0, 1'b1, 1'b0);
    idle(LAT + 3);
    check_eq("relu count", res_q.size(), 2);
    expect_result("relu on", 0);
    expect_result("relu off", -90);

    // Positive and negative saturation.
    start_test();
    beat(fill(32767), 0, 1'b0, 1'b0);
    beat(fill(32767), 0, 1'b1, 1'b0);
    beat(fill(-32768), 0, 1'b0, 1'b0);
    beat(fill(-32768), 0, 1'b1, 1'b0);
    idle(LAT + 3);
    check_eq("sat count", res_q.size(), 2);
    expect_result("sat pos", 524287);
    expect_result("sat neg", -524288);

    // Bubbles between beats.
    start_test();
    beat(ramp(), 0, 1'b0, 1'b0);
    idle(2);
    beat(ramp(), 0, 1'b0, 1'b0);
    idle(2);
    beat(ramp(), 0, 1'b1, 1'b0);
    idle(LAT + 3);
    check_eq("bubble count", res_q.size(), 1);
    expect_result("bubble sum", 135);

    // Reset mid-group discards in-flight beats.
    start_test();
    beat(ramp(), 0, 1'b0, 1'b0);
    beat(ramp(), 0, 1'b0, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(LAT + 3);
    check_eq("flush count", res_q.size(), 0);
    beat(ramp(), 0, 1'b1, 1'b0);
    idle(LAT + 3);
    check_eq("post-reset count", res_q.size(), 1);
    expect_result("post-reset sum", 45);

    // 65 beats without last: forced close on the 64th.
    start_test();
    check_eq("ovf before", err_ovf, 0);
    c64 = 0;
    for (int i = 0; i < MAX_CH + 1; i++) begin
      beat(fill(1), 0, 1'b0, 1'b0);
      if (i == MAX_CH - 1) c64 = beat_cyc;
    end
    idle(LAT + 3);
    check_eq("ovf count", res_q.size(), 1);
    if (res_cyc_q.size() != 0) check_eq("ovf latency", res_cyc_q[0] - c64 + 1, LAT);
    expect_result("ovf sum", 9 * MAX_CH);
    check_eq("ovf sticky", err_ovf, 1);
    idle(4);
    check_eq("ovf still set", err_ovf, 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check_eq("ovf cleared", err_ovf, 0);
    check_eq("out_sum cleared", out_sum, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
